nibble_serial_adder_ctrl: RTL and testbench
===========================================

Name: nibble_serial_adder_ctrl

Overview:
Sequencer that performs W-bit addition (W = 4*NIBBLES) by driving the team's existing 4-bit ripple adder one nibble per clock, LSB nibble first. It sits directly upstream and downstream of that adder. It feeds the adder's a/b/cin bits and captures its s/cout each cycle, chaining cout into the next nibble's cin. Operands arrive and the result leaves on valid/ready handshakes.

Parameters:
NIBBLES, 4, number of 4-bit slices per operand (W = 4*NIBBLES); legal range is 1 or more.

Ports:
clk  input  1  single system clock, rising edge
rst_n  input  1  synchronous, active-low reset
in_valid  input  1  operand pair present
in_ready  output  1  block can accept operands
op_a  input  W  operand A
op_b  input  W  operand B
cin_in  input  1  carry into nibble 0
add_a  output  4  nibble of A to adder (bit i drives adder a_i)
add_b  output  4  nibble of B to adder
add_cin  output  1  carry to adder cin
add_s  input  4  adder sum bits s3..s0 (combinational from add_*)
add_cout  input  1  adder carry out
out_valid  output  1  result held
out_ready  input  1  consumer takes result
sum  output  W  result, modulo 2^W
cout_out  output  1  carry out of the top nibble

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low (clk, rst_n). When rst_n=0 at a rising edge: state becomes IDLE, idx=0, carry=0, sum=0, cout_out=0, out_valid=0, operand registers cleared. in_ready is forced to 0 while rst_n=0.
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. When in_valid&in_ready is high at an edge: capture a_reg=op_a, b_reg=op_b, carry=cin_in, idx=0, clear sum_reg, then go to RUN.
- RUN: in_ready=0. add_a=a_reg[4*idx+:4], add_b=b_reg[4*idx+:4], add_cin=carry. All three are driven combinationally from registers only.
  - Each edge: sum_reg[4*idx+:4] <= add_s, carry <= add_cout, idx <= idx+1.
  - On the edge where idx==NIBBLES-1: cout_out <= add_cout, out_valid <= 1, state goes to DONE.
- RUN lasts exactly NIBBLES cycles. out_valid rises NIBBLES edges after the accept edge.
- Outside RUN, add_a, add_b and add_cin are driven to 0.
- DONE: out_valid=1. sum and cout_out are stable, in_ready=0, and in_valid is ignored. When out_valid&out_ready is high at an edge: out_valid <= 0 and state goes to IDLE. There is no same-cycle re-accept.
- Sustained throughput is one operation per NIBBLES+2 cycles when out_ready is held high.
- sum and cout_out keep their last values after the handshake until the next result is written. They are cleared only by reset.
- Arithmetic: {cout_out,sum} = op_a + op_b + cin_in as a (W+1)-bit value. No overflow flag.
- NIBBLES=1 degenerates to a single RUN cycle.
- idx width is max(1, clog2(NIBBLES)). idx never exceeds NIBBLES-1.
- Reset at any point (RUN or DONE) aborts the operation. The partial result is discarded and out_valid is never asserted for it.
- The block does not register add_s or add_cout beyond the per-nibble capture. The adder must settle within one clock period.

Decomposition:
- Shared package: the state enum (IDLE/RUN/DONE) and the constant NIBBLE_W=4.
- No sub-module inside this block. The existing 4-bit adder stays a separate instance, connected in a small top wrapper (nibble_serial_adder_top) that bit-maps add_a/add_b/add_s onto the adder's a0..a3, b0..b3 and s0..s3 ports.

Test Plan:
All scenarios use NIBBLES=4 unless stated; the real 4-bit adder is instantiated in the wrapper.
1. 0x1234 + 0x4321, cin_in=0, out_ready=1 -> sum=0x5555, cout_out=0. out_valid rises exactly 4 edges after accept. add_cin sequence is 0,0,0,0.
2. 0xFFFF + 0x0001, cin_in=0 -> sum=0x0000, cout_out=1. add_cin sequence is 0,1,1,1. add_a nibbles are F,F,F,F.
3. 0xFFFF + 0xFFFF, cin_in=1 -> sum=0xFFFF, cout_out=1. Then 0x0000 + 0x0000, cin_in=0 -> sum=0x0000, cout_out=0; this confirms no stale carry survives.
4. Backpressure: hold out_ready=0 for 5 cycles after out_valid.
   - Required: sum and cout_out stable, in_ready=0, and an in_valid pulse with 0xAAAA is not captured.
   - On release: handshake completes, IDLE follows, in_ready=1 the next cycle.
5. Reset mid-RUN (rst_n=0 for one edge after 2 nibbles of 0x00FF+0x0001):
   - Required: IDLE, out_valid=0, sum=0, cout_out=0, in_ready=0 during reset.
   - Then 0x0001 + 0x0001 -> 0x0002, cout_out=0.
6. NIBBLES=1 exhaustive: all 512 combinations of a, b and cin -> {cout_out,sum} equals a+b+cin each time. Latency is 1 edge, and throughput is one operation per 3 cycles with out_ready=1.

Source files
------------

// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared types and constants for the nibble-serial adder sequencer.
package nibble_serial_adder_ctrl_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/nibble_adder4.sv
// Existing 4-bit ripple-carry adder with bit-level ports; purely combinational.
module nibble_adder4 (
  input  logic a0,
  input  logic a1,
  input  logic a2,
  input  logic a3,
  input  logic b0,
  input  logic b1,
  input  logic b2,
  input  logic b3,
  input  logic cin,
  output logic s0,
  output logic s1,
  output logic s2,
  output logic s3,
  output logic cout
);

  logic c1_s;
  logic c2_s;
  logic c3_s;

  assign s0   = a0 ^ b0 ^ cin;
  assign c1_s = (a0 & b0) | (cin & (a0 ^ b0));
  assign s1   = a1 ^ b1 ^ c1_s;
  assign c2_s = (a1 & b1) | (c1_s & (a1 ^ b1));
  assign s2   = a2 ^ b2 ^ c2_s;
  assign c3_s = (a2 & b2) | (c2_s & (a2 ^ b2));
  assign s3   = a3 ^ b3 ^ c3_s;
  assign cout = (a3 & b3) | (c3_s & (a3 ^ b3));

endmodule

// File: rtl/nibble_serial_adder_top.sv
// Wrapper pairing the sequencer with the existing 4-bit adder, bit-mapping the
// nibble buses onto the adder's individual a/b/s pins.
module nibble_serial_adder_top
  import nibble_serial_adder_ctrl_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0] op_a,
  input  logic [NIBBLE_W*NIBBLES-1:0] op_b,
  input  logic                        cin_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0] sum,
  output logic                        cout_out
);

  logic [NIBBLE_W-1:0] add_a_s;
  logic [NIBBLE_W-1:0] add_b_s;
  logic [NIBBLE_W-1:0] add_s_s;
  logic                add_cin_s;
  logic                add_cout_s;

  nibble_serial_adder_ctrl #(.NIBBLES(NIBBLES)) u_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .cin_in    (cin_in),
    .add_a     (add_a_s),
    .add_b     (add_b_s),
    .add_cin   (add_cin_s),
    .add_s     (add_s_s),
    .add_cout  (add_cout_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout_out  (cout_out)
  );

  nibble_adder4 u_adder (
    .a0   (add_a_s[0]),
    .a1   (add_a_s[1]),
    .a2   (add_a_s[2]),
    .a3   (add_a_s[3]),
    .b0   (add_b_s[0]),
    .b1   (add_b_s[1]),
    .b2   (add_b_s[2]),
    .b3   (add_b_s[3]),
    .cin  (add_cin_s),
    .s0   (add_s_s[0]),
    .s1   (add_s_s[1]),
    .s2   (add_s_s[2]),
    .s3   (add_s_s[3]),
    .cout (add_cout_s)
  );

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Sequencer that drives an external 4-bit adder one nibble per clock, LSB first,
// chaining the adder carry between nibbles; operands and result use valid/ready.
module nibble_serial_adder_ctrl
  import nibble_serial_adder_ctrl_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0] op_a,
  input  logic [NIBBLE_W*NIBBLES-1:0] op_b,
  input  logic                        cin_in,
  output logic [NIBBLE_W-1:0]         add_a,
  output logic [NIBBLE_W-1:0]         add_b,
  output logic                        add_cin,
  input  logic [NIBBLE_W-1:0]         add_s,
  input  logic                        add_cout,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0] sum,
  output logic                        cout_out
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_e           state_q,     state_d;
  logic [IDX_W-1:0] idx_q,       idx_d;
  logic             carry_q,     carry_d;
  logic [W-1:0]     a_q,         a_d;
  logic [W-1:0]     b_q,         b_d;
  logic [W-1:0]     acc_q,       acc_d;
  logic [W-1:0]     sum_q,       sum_d;
  logic             cout_q,      cout_d;
  logic             out_valid_q, out_valid_d;

  // Handshake qualifier: never ready while reset is held.
  assign in_ready  = rst_n && (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout_out  = cout_q;

  // Next-state, datapath update and adder drive. The accumulator is separate
  // from sum_q so the published result stays put while the next one is built.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    out_valid_d = out_valid_q;
    add_a       = '0;
    add_b       = '0;
    add_cin     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          a_d     = op_a;
          b_d     = op_b;
          carry_d = cin_in;
          idx_d   = '0;
          acc_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        add_a   = a_q[NIBBLE_W*idx_q +: NIBBLE_W];
        add_b   = b_q[NIBBLE_W*idx_q +: NIBBLE_W];
        add_cin = carry_q;
        acc_d[NIBBLE_W*idx_q +: NIBBLE_W] = add_s;
        carry_d = add_cout;
        if (idx_q == LAST_IDX) begin
          idx_d       = '0;
          sum_d       = acc_d;
          cout_d      = add_cout;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_DONE: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench: NIBBLES=4 and NIBBLES=1 sequencers each paired with the
// real 4-bit adder, checked against plain integer addition.
module tb_nibble_serial_adder_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   cyc = 0;
  int   tests_run = 0;
  int   fails = 0;

  // Free-running edge counter used for latency/throughput checks.
  always @(posedge clk) cyc <= cyc + 1;

  logic        in_valid4, out_ready4, cin4;
  logic [15:0] op_a4, op_b4;
  wire         in_ready4, out_valid4, cout4, add_cin4, add_cout4;
  wire  [3:0]  add_a4, add_b4, add_s4;
  wire  [15:0] sum4;

  logic        in_valid1, out_ready1, cin1;
  logic [3:0]  op_a1, op_b1;
  wire         in_ready1, out_valid1, cout1, add_cin1, add_cout1;
  wire  [3:0]  add_a1, add_b1, add_s1;
  wire  [3:0]  sum1;

  nibble_serial_adder_ctrl #(.NIBBLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .op_a(op_a4), .op_b(op_b4), .cin_in(cin4),
    .add_a(add_a4), .add_b(add_b4), .add_cin(add_cin4),
    .add_s(add_s4), .add_cout(add_cout4),
    .out_valid(out_valid4), .out_ready(out_ready4), .sum(sum4), .cout_out(cout4)
  );

  nibble_adder4 adder4 (
    .a0(add_a4[0]), .a1(add_a4[1]), .a2(add_a4[2]), .a3(add_a4[3]),
    .b0(add_b4[0]), .b1(add_b4[1]), .b2(add_b4[2]), .b3(add_b4[3]),
    .cin(add_cin4),
    .s0(add_s4[0]), .s1(add_s4[1]), .s2(add_s4[2]), .s3(add_s4[3]),
    .cout(add_cout4)
  );

  nibble_serial_adder_ctrl #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .op_a(op_a1), .op_b(op_b1), .cin_in(cin1),
    .add_a(add_a1), .add_b(add_b1), .add_cin(add_cin1),
    .add_s(add_s1), .add_cout(add_cout1),
    .out_valid(out_valid1), .out_ready(out_ready1), .sum(sum1), .cout_out(cout1)
  );

  nibble_adder4 adder1 (
    .a0(add_a1[0]), .a1(add_a1[1]), .a2(add_a1[2]), .a3(add_a1[3]),
    .b0(add_b1[0]), .b1(add_b1[1]), .b2(add_b1[2]), .b3(add_b1[3]),
    .cin(add_cin1),
    .s0(add_s1[0]), .s1(add_s1[1]), .s2(add_s1[2]), .s3(add_s1[3]),
    .cout(add_cout1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int prev_accept4 = -1;

  // One NIBBLES=4 operation, entered and left at a negedge with the DUT idle.
  // hold = cycles out_ready stays low after out_valid (with an ignored in_valid pulse).
  task automatic run4(input logic [15:0] a, input logic [15:0] b, input logic cin, input int hold);
    logic [16:0] expv;
    logic [16:0] mask;
    logic [16:0] part;
    int          accept_cyc;
    expv = {1'b0, a} + {1'b0, b} + 17'(cin);
    check("idle_in_ready", 64'(in_ready4), 64'd1);
    check("idle_add_a_zero", 64'(add_a4), 64'd0);
    in_valid4  = 1'b1;
    op_a4      = a;
    op_b4      = b;
    cin4       = cin;
    out_ready4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) begin
        in_valid4  = 1'b0;
        accept_cyc = cyc;
        if (prev_accept4 >= 0) check("throughput4", 64'(accept_cyc - prev_accept4), 64'd6);
      end
      mask = (17'd1 << (4 * i)) - 17'd1;
      part = ({1'b0, a} & mask) + ({1'b0, b} & mask) + 17'(cin);
      check("add_a_nibble", 64'(add_a4), 64'((a >> (4 * i)) & 16'hF));
      check("add_b_nibble", 64'(add_b4), 64'((b >> (4 * i)) & 16'hF));
      check("add_cin_chain", 64'(add_cin4), 64'(part[4 * i]));
      check("run_out_valid_low", 64'(out_valid4), 64'd0);
      check("run_in_ready_low", 64'(in_ready4), 64'd0);
    end
    @(negedge clk);
    check("latency_out_valid", 64'(out_valid4), 64'd1);
    check("sum4", 64'(sum4), 64'(expv[15:0]));
    check("cout4", 64'(cout4), 64'(expv[16]));
    check("done_add_a_zero", 64'(add_a4), 64'd0);
    check("done_in_ready_low", 64'(in_ready4), 64'd0);
    for (int h = 0; h < hold; h++) begin
      in_valid4 = (h == 1);
      op_a4     = 16'hAAAA;
      op_b4     = 16'hAAAA;
      @(negedge clk);
      check("bp_out_valid", 64'(out_valid4), 64'd1);
      check("bp_sum_stable", 64'(sum4), 64'(expv[15:0]));
      check("bp_cout_stable", 64'(cout4), 64'(expv[16]));
      check("bp_in_ready_low", 64'(in_ready4), 64'd0);
    end
    in_valid4  = 1'b0;
    out_ready4 = 1'b1;
    @(negedge clk);
    out_ready4 = 1'b0;
    check("post_hs_out_valid", 64'(out_valid4), 64'd0);
    check("post_hs_in_ready", 64'(in_ready4), 64'd1);
    check("post_hs_sum_kept", 64'(sum4), 64'(expv[15:0]));
    check("post_hs_cout_kept", 64'(cout4), 64'(expv[16]));
    prev_accept4 = (hold == 0) ? accept_cyc : -1;
  endtask

  initial begin
    logic [4:0] exp5;
    int         acc1;
    int         prev1;

    rst_n = 1'b0;
    in_valid4 = 1'b0; out_ready4 = 1'b0; cin4 = 1'b0; op_a4 = 16'h0; op_b4 = 16'h0;
    in_valid1 = 1'b0; out_ready1 = 1'b1; cin1 = 1'b0; op_a1 = 4'h0; op_b1 = 4'h0;
    repeat (2) @(negedge clk);
    check("rst_in_ready_low", 64'(in_ready4), 64'd0);
    check("rst_out_valid", 64'(out_valid4), 64'd0);
    check("rst_sum", 64'(sum4), 64'd0);
    check("rst_cout", 64'(cout4), 64'd0);
    check("rst_add_cin", 64'(add_cin4), 64'd0);
    rst_n = 1'b1;
    #1;

    // Directed cases: plain add, full carry ripple, carry-in saturation, stale-carry check.
    run4(16'h1234, 16'h4321, 1'b0, 0);
    run4(16'hFFFF, 16'h0001, 1'b0, 0);
    run4(16'hFFFF, 16'hFFFF, 1'b1, 0);
    run4(16'h0000, 16'h0000, 1'b0, 0);
    run4(16'h8765, 16'h1F0E, 1'b1, 5);
    run4(16'h0F0F, 16'hF0F1, 1'b0, 0);

    // Abort mid-operation after two nibbles.
    in_valid4 = 1'b1; op_a4 = 16'h00FF; op_b4 = 16'h0001; cin4 = 1'b0;
    @(negedge clk);
    in_valid4 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_in_ready_low", 64'(in_ready4), 64'd0);
    @(negedge clk);
    check("abort_out_valid", 64'(out_valid4), 64'd0);
    check("abort_sum", 64'(sum4), 64'd0);
    check("abort_cout", 64'(cout4), 64'd0);
    check("abort_add_a", 64'(add_a4), 64'd0);
    check("abort_in_ready_rst", 64'(in_ready4), 64'd0);
    rst_n = 1'b1;
    #1;
    check("abort_in_ready_rel", 64'(in_ready4), 64'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("abort_no_valid", 64'(out_valid4), 64'd0);
    end
    prev_accept4 = -1;
    run4(16'h0001, 16'h0001, 1'b0, 0);

    for (int r = 0; r < 24; r++) begin
      run4(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
    end

    // NIBBLES=1: exhaustive, out_ready held high.
    prev1 = -1;
    for (int v = 0; v < 512; v++) begin
      op_a1 = 4'(v);
      op_b1 = 4'(v >> 4);
      cin1  = 1'(v >> 8);
      exp5  = 5'(op_a1) + 5'(op_b1) + 5'(cin1);
      check("n1_in_ready", 64'(in_ready1), 64'd1);
      in_valid1 = 1'b1;
      @(negedge clk);
      in_valid1 = 1'b0;
      acc1 = cyc;
      if (prev1 >= 0) check("n1_throughput", 64'(acc1 - prev1), 64'd3);
      prev1 = acc1;
      check("n1_add_a", 64'(add_a1), 64'(op_a1));
      check("n1_add_cin", 64'(add_cin1), 64'(cin1));
      check("n1_run_no_valid", 64'(out_valid1), 64'd0);
      @(negedge clk);
      check("n1_out_valid", 64'(out_valid1), 64'd1);
      check("n1_result", 64'({cout1, sum1}), 64'(exp5));
      @(negedge clk);
      check("n1_hs_done", 64'(out_valid1), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
